// File: rtl/rvh_l1d_amo_req_sched.sv
// In-order two-port store scheduler that steers AMO/LR/SC to port 0 only, parking displaced requests in a one-entry replay register.
// Optional RVH_L1D_AMO_SCHED_STALL_CNT_EN adds a 16-bit saturating scheduler-stall counter on perf_stall_cnt_o.
module rvh_l1d_amo_req_sched #(
    parameter int N_PORT         = 2,
    parameter int ROB_TAG_WIDTH  = 4,
    parameter int PREG_TAG_WIDTH = 6,
    parameter int STU_OP_WIDTH   = 5,
    parameter int PADDR_WIDTH    = 56,
    parameter int XLEN           = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PORT-1:0]                ls_req_vld_i,
    input  logic [N_PORT-1:0]                ls_req_is_fence_i,
    input  logic [N_PORT*ROB_TAG_WIDTH-1:0]  ls_req_rob_tag_i,
    input  logic [N_PORT*PREG_TAG_WIDTH-1:0] ls_req_prd_i,
    input  logic [N_PORT*STU_OP_WIDTH-1:0]   ls_req_opcode_i,
    input  logic [N_PORT*PADDR_WIDTH-1:0]    ls_req_paddr_i,
    input  logic [N_PORT*XLEN-1:0]           ls_req_data_i,
    output logic [N_PORT-1:0]                ls_req_rdy_o,
    output logic [N_PORT-1:0]                sched_req_vld_o,
    output logic [N_PORT-1:0]                sched_req_is_fence_o,
    output logic [N_PORT*ROB_TAG_WIDTH-1:0]  sched_req_rob_tag_o,
    output logic [N_PORT*PREG_TAG_WIDTH-1:0] sched_req_prd_o,
    output logic [N_PORT*STU_OP_WIDTH-1:0]   sched_req_opcode_o,
    output logic [N_PORT*PADDR_WIDTH-1:0]    sched_req_paddr_o,
    output logic [N_PORT*XLEN-1:0]           sched_req_data_o,
    input  logic [N_PORT-1:0]                sched_req_rdy_i,
    input  logic                             in_amo_state_i,
    input  logic                             kill_i,
    output logic [15:0]                      perf_stall_cnt_o,
    output logic                             dbg_state_o
);

    // Handshake: a transfer on a port happens in a cycle where its vld and rdy
    // are both 1; vld never depends on the rdy of the same port.

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    function automatic logic is_amo(input logic [STU_OP_WIDTH-1:0] op);
        return (op >= STU_OP_WIDTH'(7)) && (op <= STU_OP_WIDTH'(28));
    endfunction

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       capture;

    logic                      rpl_is_fence_q;
    logic [ROB_TAG_WIDTH-1:0]  rpl_rob_tag_q;
    logic [PREG_TAG_WIDTH-1:0] rpl_prd_q;
    logic [STU_OP_WIDTH-1:0]   rpl_opcode_q;
    logic [PADDR_WIDTH-1:0]    rpl_paddr_q;
    logic [XLEN-1:0]           rpl_data_q;

    logic amo0;
    logic amo1;
    logic [N_PORT-1:0] rdy;
    logic [N_PORT-1:0] vld;

    assign amo0 = ls_req_vld_i[0] & is_amo(ls_req_opcode_i[0 +: STU_OP_WIDTH]);
    assign amo1 = ls_req_vld_i[1] & is_amo(ls_req_opcode_i[STU_OP_WIDTH +: STU_OP_WIDTH]);

    always_comb begin
        rdy     = '0;
        vld     = '0;
        state_d = state_q;
        capture = 1'b0;
        if (!rst) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            // Downstream valids are withheld under kill so nothing is sent that upstream did not hand over.
            if (!in_amo_state_i && !kill_i) begin
                if (amo0) begin
                    vld[0] = 1'b1;
                    rdy[0] = sched_req_rdy_i[0];
                    rdy[1] = sched_req_rdy_i[0];
                    if (ls_req_vld_i[1] && sched_req_rdy_i[0]) begin
                        capture = 1'b1;
                        state_d = ST_REPLAY;
                    end
                end else if (amo1) begin
                    vld[0] = ls_req_vld_i[0];
                    rdy[0] = sched_req_rdy_i[0];
                    rdy[1] = sched_req_rdy_i[0] | ~ls_req_vld_i[0];
                    if (rdy[1]) begin
                        capture = 1'b1;
                        state_d = ST_REPLAY;
                    end
                end else begin
                    vld    = ls_req_vld_i;
                    rdy[0] = sched_req_rdy_i[0];
                    rdy[1] = sched_req_rdy_i[1] & (sched_req_rdy_i[0] | ~ls_req_vld_i[0]);
                end
            end
        end else begin
            vld[0] = ~in_amo_state_i;
            if (vld[0] && sched_req_rdy_i[0]) begin
                state_d = ST_IDLE;
            end
            if (kill_i) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only port 1 is ever displaced, so the replay entry always loads from port 1.
    always_ff @(posedge clk) begin
        if (capture) begin
            rpl_is_fence_q <= ls_req_is_fence_i[1];
            rpl_rob_tag_q  <= ls_req_rob_tag_i[ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
            rpl_prd_q      <= ls_req_prd_i[PREG_TAG_WIDTH +: PREG_TAG_WIDTH];
            rpl_opcode_q   <= ls_req_opcode_i[STU_OP_WIDTH +: STU_OP_WIDTH];
            rpl_paddr_q    <= ls_req_paddr_i[PADDR_WIDTH +: PADDR_WIDTH];
            rpl_data_q     <= ls_req_data_i[XLEN +: XLEN];
        end
    end

    assign ls_req_rdy_o    = rdy;
    assign sched_req_vld_o = vld;
    assign dbg_state_o     = state_q;

    logic in_replay;
    assign in_replay = (state_q == ST_REPLAY);

    assign sched_req_is_fence_o[0] = in_replay ? rpl_is_fence_q : ls_req_is_fence_i[0];
    assign sched_req_is_fence_o[1] = ls_req_is_fence_i[1];

    assign sched_req_rob_tag_o[0 +: ROB_TAG_WIDTH] =
        in_replay ? rpl_rob_tag_q : ls_req_rob_tag_i[0 +: ROB_TAG_WIDTH];
    assign sched_req_rob_tag_o[ROB_TAG_WIDTH +: ROB_TAG_WIDTH] =
        ls_req_rob_tag_i[ROB_TAG_WIDTH +: ROB_TAG_WIDTH];

    assign sched_req_prd_o[0 +: PREG_TAG_WIDTH] =
        in_replay ? rpl_prd_q : ls_req_prd_i[0 +: PREG_TAG_WIDTH];
    assign sched_req_prd_o[PREG_TAG_WIDTH +: PREG_TAG_WIDTH] =
        ls_req_prd_i[PREG_TAG_WIDTH +: PREG_TAG_WIDTH];

    assign sched_req_opcode_o[0 +: STU_OP_WIDTH] =
        in_replay ? rpl_opcode_q : ls_req_opcode_i[0 +: STU_OP_WIDTH];
    assign sched_req_opcode_o[STU_OP_WIDTH +: STU_OP_WIDTH] =
        ls_req_opcode_i[STU_OP_WIDTH +: STU_OP_WIDTH];

    assign sched_req_paddr_o[0 +: PADDR_WIDTH] =
        in_replay ? rpl_paddr_q : ls_req_paddr_i[0 +: PADDR_WIDTH];
    assign sched_req_paddr_o[PADDR_WIDTH +: PADDR_WIDTH] =
        ls_req_paddr_i[PADDR_WIDTH +: PADDR_WIDTH];

    assign sched_req_data_o[0 +: XLEN] = in_replay ? rpl_data_q : ls_req_data_i[0 +: XLEN];
    assign sched_req_data_o[XLEN +: XLEN] = ls_req_data_i[XLEN +: XLEN];

`ifdef RVH_L1D_AMO_SCHED_STALL_CNT_EN
    // A stall is ours only when the controller would have accepted that port.
    logic        sched_stall;
    logic [15:0] stall_cnt_q;

    assign sched_stall = |(ls_req_vld_i & ~rdy & sched_req_rdy_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 16'h0;
        end else if (sched_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
`else
    assign perf_stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_rvh_l1d_amo_req_sched.sv
// Directed self-checking bench for rvh_l1d_amo_req_sched: pass-through, ordering, AMO steering, replay, kill and reset.
module tb_rvh_l1d_amo_req_sched;

    localparam int NP = 2;
    localparam int RW = 4;
    localparam int PW = 6;
    localparam int OW = 5;
    localparam int AW = 56;
    localparam int XW = 64;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     ls_req_vld_i;
    logic [NP-1:0]     ls_req_is_fence_i;
    logic [NP*RW-1:0]  ls_req_rob_tag_i;
    logic [NP*PW-1:0]  ls_req_prd_i;
    logic [NP*OW-1:0]  ls_req_opcode_i;
    logic [NP*AW-1:0]  ls_req_paddr_i;
    logic [NP*XW-1:0]  ls_req_data_i;
    logic [NP-1:0]     ls_req_rdy_o;
    logic [NP-1:0]     sched_req_vld_o;
    logic [NP-1:0]     sched_req_is_fence_o;
    logic [NP*RW-1:0]  sched_req_rob_tag_o;
    logic [NP*PW-1:0]  sched_req_prd_o;
    logic [NP*OW-1:0]  sched_req_opcode_o;
    logic [NP*AW-1:0]  sched_req_paddr_o;
    logic [NP*XW-1:0]  sched_req_data_o;
    logic [NP-1:0]     sched_req_rdy_i;
    logic              in_amo_state_i;
    logic              kill_i;
    logic [15:0]       perf_stall_cnt_o;
    logic              dbg_state_o;

    int checks;
    int failures;

    rvh_l1d_amo_req_sched #(
        .N_PORT(NP), .ROB_TAG_WIDTH(RW), .PREG_TAG_WIDTH(PW),
        .STU_OP_WIDTH(OW), .PADDR_WIDTH(AW), .XLEN(XW)
    ) dut (
        .clk(clk), .rst(rst),
        .ls_req_vld_i(ls_req_vld_i), .ls_req_is_fence_i(ls_req_is_fence_i),
        .ls_req_rob_tag_i(ls_req_rob_tag_i), .ls_req_prd_i(ls_req_prd_i),
        .ls_req_opcode_i(ls_req_opcode_i), .ls_req_paddr_i(ls_req_paddr_i),
        .ls_req_data_i(ls_req_data_i), .ls_req_rdy_o(ls_req_rdy_o),
        .sched_req_vld_o(sched_req_vld_o), .sched_req_is_fence_o(sched_req_is_fence_o),
        .sched_req_rob_tag_o(sched_req_rob_tag_o), .sched_req_prd_o(sched_req_prd_o),
        .sched_req_opcode_o(sched_req_opcode_o), .sched_req_paddr_o(sched_req_paddr_o),
        .sched_req_data_o(sched_req_data_o), .sched_req_rdy_i(sched_req_rdy_i),
        .in_amo_state_i(in_amo_state_i), .kill_i(kill_i),
        .perf_stall_cnt_o(perf_stall_cnt_o), .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after posedge, outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [OW-1:0] op,
                         input logic [RW-1:0] rob, input logic [AW-1:0] pa);
        ls_req_vld_i[k]            = v;
        ls_req_is_fence_i[k]       = 1'b0;
        ls_req_opcode_i[k*OW +: OW] = op;
        ls_req_rob_tag_i[k*RW +: RW] = rob;
        ls_req_prd_i[k*PW +: PW]    = PW'(rob) + PW'(8);
        ls_req_paddr_i[k*AW +: AW]  = pa;
        ls_req_data_i[k*XW +: XW]   = 64'hDA7A_0000_0000_0000 | XW'(rob);
    endtask

    task automatic idle_inputs();
        drive(0, 1'b0, 5'd0, 4'd0, 56'h0);
        drive(1, 1'b0, 5'd0, 4'd0, 56'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b1, 5'd0, 4'd1, 56'h100);
        drive(1, 1'b1, 5'd11, 4'd2, 56'h200);
        sched_req_rdy_i = 2'b11;
        tick();
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b00) begin failures++; $display("FAIL reset_vld: got %b expected 00", sched_req_vld_o); end
        checks++; if (ls_req_rdy_o !== 2'b00) begin failures++; $display("FAIL reset_rdy: got %b expected 00", ls_req_rdy_o); end
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL reset_state: got %b expected 0", dbg_state_o); end
        checks++; if (perf_stall_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt: got %h expected 0000", perf_stall_cnt_o); end
        tick();
        rst = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_pass_through();
        drive(0, 1'b1, 5'd0, 4'd1, 56'h0A0);
        drive(1, 1'b1, 5'd0, 4'd2, 56'h0B0);
        sched_req_rdy_i = 2'b11;
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b11) begin failures++; $display("FAIL pass_vld: got %b expected 11", sched_req_vld_o); end
        checks++; if (ls_req_rdy_o !== 2'b11) begin failures++; $display("FAIL pass_rdy: got %b expected 11", ls_req_rdy_o); end
        checks++; if (sched_req_rob_tag_o[RW +: RW] !== 4'd2) begin failures++; $display("FAIL pass_rob1: got %h expected 2", sched_req_rob_tag_o[RW +: RW]); end
        checks++; if (sched_req_paddr_o[0 +: AW] !== 56'h0A0) begin failures++; $display("FAIL pass_paddr0: got %h expected 0a0", sched_req_paddr_o[0 +: AW]); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL pass_state: got %b expected 0", dbg_state_o); end
        tick();
    endtask

    task automatic test_in_order_stall();
        drive(0, 1'b1, 5'd0, 4'd3, 56'h0C0);
        drive(1, 1'b1, 5'd0, 4'd4, 56'h0D0);
        sched_req_rdy_i = 2'b10;
        @(negedge clk);
        checks++; if (ls_req_rdy_o !== 2'b00) begin failures++; $display("FAIL order_rdy: got %b expected 00", ls_req_rdy_o); end
        tick();
        drive(0, 1'b0, 5'd0, 4'd0, 56'h0);
        @(negedge clk);
        checks++; if (ls_req_rdy_o !== 2'b10) begin failures++; $display("FAIL order_p0_idle_rdy: got %b expected 10", ls_req_rdy_o); end
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL order_state: got %b expected 0", dbg_state_o); end
        idle_inputs();
        sched_req_rdy_i = 2'b11;
        tick();
    endtask

    task automatic test_amo_port0();
        drive(0, 1'b1, 5'd11, 4'd3, 56'h300);
        drive(1, 1'b1, 5'd0, 4'd5, 56'h2000);
        sched_req_rdy_i = 2'b11;
        in_amo_state_i = 1'b0;
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b01) begin failures++; $display("FAIL amo0_vld: got %b expected 01", sched_req_vld_o); end
        checks++; if (ls_req_rdy_o !== 2'b11) begin failures++; $display("FAIL amo0_rdy: got %b expected 11", ls_req_rdy_o); end
        checks++; if (sched_req_opcode_o[0 +: OW] !== 5'd11) begin failures++; $display("FAIL amo0_op: got %0d expected 11", sched_req_opcode_o[0 +: OW]); end
        tick();
        idle_inputs();
        in_amo_state_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (sched_req_vld_o !== 2'b00) begin failures++; $display("FAIL amo0_hold_vld[%0d]: got %b expected 00", i, sched_req_vld_o); end
            checks++; if (dbg_state_o !== 1'b1) begin failures++; $display("FAIL amo0_hold_state[%0d]: got %b expected 1", i, dbg_state_o); end
            tick();
        end
        in_amo_state_i = 1'b0;
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b01) begin failures++; $display("FAIL amo0_replay_vld: got %b expected 01", sched_req_vld_o); end
        checks++; if (sched_req_rob_tag_o[0 +: RW] !== 4'd5) begin failures++; $display("FAIL amo0_replay_rob: got %0d expected 5", sched_req_rob_tag_o[0 +: RW]); end
        checks++; if (sched_req_paddr_o[0 +: AW] !== 56'h2000) begin failures++; $display("FAIL amo0_replay_paddr: got %h expected 2000", sched_req_paddr_o[0 +: AW]); end
        checks++; if (ls_req_rdy_o !== 2'b00) begin failures++; $display("FAIL amo0_replay_rdy: got %b expected 00", ls_req_rdy_o); end
        tick();
        @(negedge clk);
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL amo0_back_idle: got %b expected 0", dbg_state_o); end
        tick();
    endtask

    task automatic test_lr_port1();
        drive(0, 1'b0, 5'd0, 4'd0, 56'h0);
        drive(1, 1'b1, 5'd7, 4'd6, 56'h1000);
        sched_req_rdy_i = 2'b11;
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b00) begin failures++; $display("FAIL lr1_cap_vld: got %b expected 00", sched_req_vld_o); end
        checks++; if (ls_req_rdy_o[1] !== 1'b1) begin failures++; $display("FAIL lr1_cap_rdy1: got %b expected 1", ls_req_rdy_o[1]); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b01) begin failures++; $display("FAIL lr1_replay_vld: got %b expected 01", sched_req_vld_o); end
        checks++; if (sched_req_paddr_o[0 +: AW] !== 56'h1000) begin failures++; $display("FAIL lr1_replay_paddr: got %h expected 1000", sched_req_paddr_o[0 +: AW]); end
        checks++; if (sched_req_opcode_o[0 +: OW] !== 5'd7) begin failures++; $display("FAIL lr1_replay_op: got %0d expected 7", sched_req_opcode_o[0 +: OW]); end
        checks++; if (sched_req_data_o[0 +: XW] !== 64'hDA7A_0000_0000_0006) begin failures++; $display("FAIL lr1_replay_data: got %h expected da7a000000000006", sched_req_data_o[0 +: XW]); end
        checks++; if (sched_req_prd_o[0 +: PW] !== 6'd14) begin failures++; $display("FAIL lr1_replay_prd: got %0d expected 14", sched_req_prd_o[0 +: PW]); end
        tick();
        @(negedge clk);
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL lr1_back_idle: got %b expected 0", dbg_state_o); end
    endtask

    task automatic test_amo1_behind_stall();
        drive(0, 1'b1, 5'd0, 4'd1, 56'h40);
        drive(1, 1'b1, 5'd20, 4'd2, 56'h50);
        sched_req_rdy_i = 2'b10;
        @(negedge clk);
        checks++; if (ls_req_rdy_o !== 2'b00) begin failures++; $display("FAIL c_stall_rdy: got %b expected 00", ls_req_rdy_o); end
        checks++; if (sched_req_vld_o !== 2'b01) begin failures++; $display("FAIL c_stall_vld: got %b expected 01", sched_req_vld_o); end
        tick();
        @(negedge clk);
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL c_stall_state: got %b expected 0", dbg_state_o); end
        idle_inputs();
        sched_req_rdy_i = 2'b11;
        tick();
    endtask

    task automatic test_kill();
        drive(1, 1'b1, 5'd9, 4'd7, 56'h700);
        sched_req_rdy_i = 2'b11;
        tick();
        idle_inputs();
        in_amo_state_i = 1'b1;
        kill_i = 1'b1;
        @(negedge clk);
        checks++; if (dbg_state_o !== 1'b1) begin failures++; $display("FAIL kill_pre_state: got %b expected 1", dbg_state_o); end
        tick();
        kill_i = 1'b0;
        in_amo_state_i = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL kill_state: got %b expected 0", dbg_state_o); end
        checks++; if (sched_req_vld_o !== 2'b00) begin failures++; $display("FAIL kill_vld: got %b expected 00", sched_req_vld_o); end
        tick();
        drive(0, 1'b1, 5'd0, 4'd9, 56'h900);
        @(negedge clk);
        checks++; if (sched_req_vld_o !== 2'b01) begin failures++; $display("FAIL kill_new_vld: got %b expected 01", sched_req_vld_o); end
        checks++; if (ls_req_rdy_o[0] !== 1'b1) begin failures++; $display("FAIL kill_new_rdy: got %b expected 1", ls_req_rdy_o[0]); end
        checks++; if (sched_req_rob_tag_o[0 +: RW] !== 4'd9) begin failures++; $display("FAIL kill_new_rob: got %0d expected 9", sched_req_rob_tag_o[0 +: RW]); end
        tick();
        drive(1, 1'b1, 5'd0, 4'd10, 56'hA00);
        kill_i = 1'b1;
        @(negedge clk);
        checks++; if (ls_req_rdy_o !== 2'b00) begin failures++; $display("FAIL kill_idle_rdy: got %b expected 00", ls_req_rdy_o); end
        checks++; if (sched_req_vld_o !== 2'b00) begin failures++; $display("FAIL kill_idle_vld: got %b expected 00", sched_req_vld_o); end
        tick();
        kill_i = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_cnt();
        logic [15:0] exp_cnt;
`ifdef RVH_L1D_AMO_SCHED_STALL_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(0, 1'b1, 5'd11, 4'd1, 56'h10);
        drive(1, 1'b1, 5'd0, 4'd2, 56'h20);
        sched_req_rdy_i = 2'b11;
        in_amo_state_i = 1'b0;
        tick();
        in_amo_state_i = 1'b1;
        drive(0, 1'b0, 5'd0, 4'd0, 56'h0);
        drive(1, 1'b1, 5'd12, 4'd3, 56'h30);
        tick();
        tick();
        tick();
        @(negedge clk);
        checks++; if (perf_stall_cnt_o !== exp_cnt) begin failures++; $display("FAIL stall_cnt: got %0d expected %0d", perf_stall_cnt_o, exp_cnt); end
        checks++; if (dbg_state_o !== 1'b1) begin failures++; $display("FAIL stall_state: got %b expected 1", dbg_state_o); end
        rst = 1'b0;
        #1;
        checks++; if (ls_req_rdy_o !== 2'b00 || sched_req_vld_o !== 2'b00) begin failures++; $display("FAIL midrst_outputs: got rdy %b vld %b expected 00 00", ls_req_rdy_o, sched_req_vld_o); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (perf_stall_cnt_o !== 16'h0) begin failures++; $display("FAIL midrst_cnt: got %0d expected 0", perf_stall_cnt_o); end
        checks++; if (dbg_state_o !== 1'b0) begin failures++; $display("FAIL midrst_state: got %b expected 0", dbg_state_o); end
        in_amo_state_i = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        kill_i = 1'b0;
        in_amo_state_i = 1'b0;
        sched_req_rdy_i = 2'b00;
        ls_req_vld_i = '0;
        ls_req_is_fence_i = '0;
        ls_req_rob_tag_i = '0;
        ls_req_prd_i = '0;
        ls_req_opcode_i = '0;
        ls_req_paddr_i = '0;
        ls_req_data_i = '0;
        #1;
        test_reset();
        test_pass_through();
        test_in_order_stall();
        test_amo_port0();
        test_lr_port1();
        test_amo1_behind_stall();
        test_kill();
        test_stall_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
